// File: rtl/f32_accum_if.sv
// Handshake and result bundle between an upstream f32 producer (e.g. f32_mult)
// and the f32 accumulator.
interface f32_accum_if;
    logic        clear;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_overflow;
    logic        in_underflow;
    logic        in_ready;
    logic [31:0] acc_o;
    logic        busy;
    logic        done;
    logic        overflow_o;
    logic        underflow_o;
    logic        invalid_o;

    modport master (
        output clear, in_valid, in_data, in_overflow, in_underflow,
        input  in_ready, acc_o, busy, done, overflow_o, underflow_o, invalid_o
    );

    modport slave (
        input  clear, in_valid, in_data, in_overflow, in_underflow,
        output in_ready, acc_o, busy, done, overflow_o, underflow_o, invalid_o
    );
endinterface

// File: rtl/f32_accum.sv
// Multi-cycle IEEE-754 single-precision accumulator: acc <= acc + in_data,
// round-to-nearest-even, subnormals flushed to zero, sticky exception flags.
module f32_accum #(
    parameter logic [31:0] ACC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    f32_accum_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND} state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t      state_reg;
    logic [31:0] acc_reg;
    logic [31:0] operand_reg;
    logic        done_reg;
    logic        ovf_reg;
    logic        unf_reg;
    logic        inv_reg;

    // ---------------- unpack (operand 0 = accumulator, 1 = addend) ----------------
    logic [31:0] opnd   [2];
    logic [7:0]  f_exp  [2];
    logic [23:0] f_sig  [2];
    logic [1:0]  f_sign;
    logic [1:0]  f_zero;
    logic [1:0]  f_inf;
    logic [1:0]  f_nan;

    assign opnd[0] = acc_reg;
    assign opnd[1] = operand_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
            assign f_sign[gi] = opnd[gi][31];
            assign f_exp[gi]  = opnd[gi][30:23];
            assign f_zero[gi] = (opnd[gi][30:23] == 8'h00);
            assign f_inf[gi]  = (opnd[gi][30:23] == 8'hFF) && (opnd[gi][22:0] == 23'd0);
            assign f_nan[gi]  = (opnd[gi][30:23] == 8'hFF) && (opnd[gi][22:0] != 23'd0);
            // Subnormal fractions are discarded: FTZ treats exp==0 as an exact zero.
            assign f_sig[gi]  = f_zero[gi] ? 24'd0 : {1'b1, opnd[gi][22:0]};
        end
    endgenerate

    logic        any_nan;
    logic [31:0] special_val_next;
    assign any_nan = (|f_nan) | (f_inf[0] & f_inf[1] & (f_sign[0] ^ f_sign[1]));
    assign special_val_next = any_nan  ? QNAN :
                              f_inf[0] ? opnd[0] : opnd[1];

    logic [1:0]  u_sign_reg;
    logic [7:0]  u_exp_reg [2];
    logic [23:0] u_sig_reg [2];
    logic        special_reg;
    logic        special_inv_reg;
    logic [31:0] special_val_reg;
    logic        zero_sign_reg;

    // ---------------- align ----------------
    logic        a_big;
    logic        sign_big, sign_small;
    logic [7:0]  exp_big, exp_small, diff;
    logic [23:0] sig_big, sig_small;
    logic [53:0] shift_wide;
    logic [26:0] aligned_small;

    assign a_big      = {u_exp_reg[0], u_sig_reg[0]} >= {u_exp_reg[1], u_sig_reg[1]};
    assign sign_big   = a_big ? u_sign_reg[0] : u_sign_reg[1];
    assign sign_small = a_big ? u_sign_reg[1] : u_sign_reg[0];
    assign exp_big    = a_big ? u_exp_reg[0]  : u_exp_reg[1];
    assign exp_small  = a_big ? u_exp_reg[1]  : u_exp_reg[0];
    assign sig_big    = a_big ? u_sig_reg[0]  : u_sig_reg[1];
    assign sig_small  = a_big ? u_sig_reg[1]  : u_sig_reg[0];
    assign diff       = exp_big - exp_small;
    assign shift_wide = {sig_small, 3'b000, 27'd0} >> diff[4:0];
    // Bits shifted past the guard/round positions collapse into the sticky LSB.
    assign aligned_small = (diff >= 8'd26) ? {26'd0, |sig_small}
                         : {shift_wide[53:28], shift_wide[27] | (|shift_wide[26:0])};

    logic        al_sign_reg;
    logic        al_sub_reg;
    logic [7:0]  al_exp_reg;
    logic [26:0] al_ma_reg;
    logic [26:0] al_mb_reg;

    // ---------------- add ----------------
    logic [27:0] sum_next;
    assign sum_next = al_sub_reg ? ({1'b0, al_ma_reg} - {1'b0, al_mb_reg})
                                 : ({1'b0, al_ma_reg} + {1'b0, al_mb_reg});

    logic [27:0] sum_reg;
    logic        ad_sign_reg;
    logic [7:0]  ad_exp_reg;

    // ---------------- normalise + round ----------------
    logic [4:0]         lz;
    logic [26:0]        nm;
    logic signed [9:0]  ne;
    logic signed [9:0]  re;
    logic               inc;
    logic [24:0]        rnd;
    logic [22:0]        frac;
    logic [31:0]        res_val;
    logic               res_ovf;
    logic               res_unf;
    logic               res_inv;

    always_comb begin
        lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (sum_reg[i]) lz = 5'(26 - i);
        end
    end

    always_comb begin
        nm      = 27'd0;
        ne      = 10'sd0;
        re      = 10'sd0;
        inc     = 1'b0;
        rnd     = 25'd0;
        frac    = 23'd0;
        res_val = 32'd0;
        res_ovf = 1'b0;
        res_unf = 1'b0;
        res_inv = 1'b0;

        if (sum_reg[27]) begin
            nm = {sum_reg[27:2], sum_reg[1] | sum_reg[0]};
            ne = $signed({2'b00, ad_exp_reg}) + 10'sd1;
        end else begin
            nm = sum_reg[26:0] << lz;
            ne = $signed({2'b00, ad_exp_reg}) - $signed({5'd0, lz});
        end

        inc  = nm[2] & (nm[1] | nm[0] | nm[3]);
        rnd  = {1'b0, nm[26:3]} + {24'd0, inc};
        re   = ne + (rnd[24] ? 10'sd1 : 10'sd0);
        frac = rnd[24] ? rnd[23:1] : rnd[22:0];

        if (special_reg) begin
            res_val = special_val_reg;
            res_inv = special_inv_reg;
        end else if (sum_reg == 28'd0) begin
            // Exact cancellation gives +0; only -0 + -0 keeps the negative sign.
            res_val = {zero_sign_reg, 31'd0};
        end else if (re >= 10'sd255) begin
            res_val = {ad_sign_reg, 8'hFF, 23'd0};
            res_ovf = 1'b1;
        end else if (re <= 10'sd0) begin
            res_val = {ad_sign_reg, 31'd0};
            res_unf = 1'b1;
        end else begin
            res_val = {ad_sign_reg, re[7:0], frac};
        end
    end

    // ---------------- datapath pipeline registers ----------------
    always_ff @(posedge clk) begin
        if (state_reg == UNPACK) begin
            u_sign_reg      <= f_sign;
            for (int i = 0; i < 2; i++) begin
                u_exp_reg[i] <= f_exp[i];
                u_sig_reg[i] <= f_sig[i];
            end
            special_reg     <= any_nan | (|f_inf);
            special_inv_reg <= any_nan;
            special_val_reg <= special_val_next;
            zero_sign_reg   <= f_sign[0] & f_sign[1];
        end
        if (state_reg == ALIGN) begin
            al_sign_reg <= sign_big;
            al_sub_reg  <= sign_big ^ sign_small;
            al_exp_reg  <= exp_big;
            al_ma_reg   <= {sig_big, 3'b000};
            al_mb_reg   <= aligned_small;
        end
        if (state_reg == ADD) begin
            sum_reg     <= sum_next;
            ad_sign_reg <= al_sign_reg;
            ad_exp_reg  <= al_exp_reg;
        end
    end

    // ---------------- control FSM with registered outputs ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            acc_reg     <= ACC_RESET;
            operand_reg <= 32'd0;
            done_reg    <= 1'b0;
            ovf_reg     <= 1'b0;
            unf_reg     <= 1'b0;
            inv_reg     <= 1'b0;
        end else if (bus.clear) begin
            state_reg <= IDLE;
            acc_reg   <= ACC_RESET;
            done_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
            inv_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.in_valid) begin
                        operand_reg <= bus.in_data;
                        ovf_reg     <= ovf_reg | bus.in_overflow;
                        unf_reg     <= unf_reg | bus.in_underflow;
                        state_reg   <= UNPACK;
                    end
                end
                UNPACK: state_reg <= ALIGN;
                ALIGN:  state_reg <= ADD;
                ADD:    state_reg <= NORM;
                // Result is committed here so acc_o and done are both visible in ROUND.
                NORM: begin
                    acc_reg   <= res_val;
                    ovf_reg   <= ovf_reg | res_ovf;
                    unf_reg   <= unf_reg | res_unf;
                    inv_reg   <= inv_reg | res_inv;
                    done_reg  <= 1'b1;
                    state_reg <= ROUND;
                end
                ROUND: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (state_reg == IDLE) && !bus.clear;
    assign bus.busy        = (state_reg != IDLE);
    assign bus.done        = done_reg;
    assign bus.acc_o       = acc_reg;
    assign bus.overflow_o  = ovf_reg;
    assign bus.underflow_o = unf_reg;
    assign bus.invalid_o   = inv_reg;
endmodule

// File: tb/tb_f32_accum.sv
// Directed-vector bench for f32_accum: one task per scenario, inline checks
// against hand-computed IEEE-754 results.
module tb_f32_accum;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    f32_accum_if bus();

    f32_accum #(.ACC_RESET(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one operand, then watches 8 cycles; reports done latency, busy and done counts.
    task automatic run_op(input logic [31:0] d, input logic ovf, input logic unf,
                          output int lat, output int busy_cnt, output int done_cnt);
        int wait_cnt;
        lat = -1; busy_cnt = 0; done_cnt = 0; wait_cnt = 0;
        @(negedge clk);
        while (!bus.in_ready && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        checks++;
        if (!bus.in_ready) begin
            errors++;
            $display("FAIL run_op_ready_timeout: in_ready=%b required 1", bus.in_ready);
        end
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_overflow = ovf; bus.in_underflow = unf;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0; bus.in_overflow = 1'b0; bus.in_underflow = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (lat < 0) lat = k;
            end
        end
        $display("op in=%h ovf=%b unf=%b -> acc=%h lat=%0d busy=%0d flags o/u/i=%b%b%b",
                 d, ovf, unf, bus.acc_o, lat, busy_cnt, bus.overflow_o, bus.underflow_o, bus.invalid_o);
    endtask

    task automatic do_clear();
        @(negedge clk);
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
    endtask

    task automatic set_acc(input logic [31:0] v);
        int lat, bc, dc;
        do_clear();
        run_op(v, 1'b0, 1'b0, lat, bc, dc);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.acc_o !== 32'h0) begin errors++; $display("FAIL reset_acc: acc_o=%h required %h", bus.acc_o, 32'h0); end
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL reset_done_busy: done=%b busy=%b required 0 0", bus.done, bus.busy); end
        checks++; if ({bus.overflow_o, bus.underflow_o, bus.invalid_o} !== 3'b000) begin errors++; $display("FAIL reset_flags: flags=%b required 000", {bus.overflow_o, bus.underflow_o, bus.invalid_o}); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: in_ready=%b required 1", bus.in_ready); end
    endtask

    task automatic test_basic_add();
        int lat, bc, dc;
        do_clear();
        run_op(32'h3F80_0000, 1'b0, 1'b0, lat, bc, dc);
        checks++; if (bus.acc_o !== 32'h3F80_0000) begin errors++; $display("FAIL basic_first: acc_o=%h required %h", bus.acc_o, 32'h3F80_0000); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency: done at cycle %0d required 5", lat); end
        checks++; if (bc !== 5) begin errors++; $display("FAIL basic_busy: busy cycles %0d required 5", bc); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL basic_done_width: done cycles %0d required 1", dc); end
        run_op(32'h4000_0000, 1'b0, 1'b0, lat, bc, dc);
        checks++; if (bus.acc_o !== 32'h4040_0000) begin errors++; $display("FAIL basic_second: acc_o=%h required %h", bus.acc_o, 32'h4040_0000); end
        checks++; if (lat !== 5 || bc !== 5) begin errors++; $display("FAIL basic_second_timing: lat=%0d busy=%0d required 5 5", lat, bc); end
    endtask

    task automatic test_cancel_ftz();
        int lat, bc, dc;
        set_acc(32'h3F80_0000);
        run_op(32'hBF80_0000, 1'b0, 1'b0, lat, bc, dc);
        checks++; if (bus.acc_o !== 32'h0) begin errors++; $display("FAIL cancel_acc: acc_o=%h required %h", bus.acc_o, 32'h0); end
        checks++; if ({bus.overflow_o, bus.underflow_o, bus.invalid_o} !== 3'b000) begin errors++; $display("FAIL cancel_flags: flags=%b required 000", {bus.overflow_o, bus.underflow_o, bus.invalid_o}); end
        run_op(32'h0000_0001, 1'b0, 1'b0, lat, bc, dc);
        checks++; if (bus.acc_o !== 32'h0) begin errors++; $display("FAIL ftz_acc: acc_o=%h required %h", bus.acc_o, 32'h0); end
        checks++; if (bus.underflow_o !== 1'b0) begin errors++; $display("FAIL ftz_underflow: underflow_o=%b required 0", bus.underflow_o); end
    endtask

    task automatic test_rounding();
        int lat, bc, dc;
        set_acc(32'h3F80_0000);
        run_op(32'h3380_0000, 1'b0, 1'b0, lat, bc, dc);
        checks++; if (bus.acc_o !== 32'h3F80_0000) begin errors++; $display("FAIL round_tie_even: acc_o=%h required %h", bus.acc_o, 32'h3F80_0000); end
        set_acc(32'h3F80_0001);
        run_op(32'h3380_0000, 1'b0, 1'b0, lat, bc, dc);
        checks++; if (bus.acc_o !== 32'h3F80_0002) begin errors++; $display("FAIL round_tie_odd: acc_o=%h required %h", bus.acc_o, 32'h3F80_0002); end
    endtask

    task automatic test_overflow();
        int lat, bc, dc;
        set_acc(32'h7F7F_FFFF);
        run_op(32'h7F7F_FFFF, 1'b0, 1'b0, lat, bc, dc);
        checks++; if (bus.acc_o !== 32'h7F80_0000) begin errors++; $display("FAIL ovf_acc: acc_o=%h required %h", bus.acc_o, 32'h7F80_0000); end
        checks++; if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag: overflow_o=%b required 1", bus.overflow_o); end
        run_op(32'h3F80_0000, 1'b0, 1'b0, lat, bc, dc);
        checks++; if (bus.acc_o !== 32'h7F80_0000 || bus.overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky: acc_o=%h overflow_o=%b required %h 1", bus.acc_o, bus.overflow_o, 32'h7F80_0000); end
        do_clear();
        @(negedge clk);
        checks++; if (bus.acc_o !== 32'h0 || bus.overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_clear: acc_o=%h overflow_o=%b required 0 0", bus.acc_o, bus.overflow_o); end
    endtask

    task automatic test_invalid_sticky();
        int lat, bc, dc;
        set_acc(32'h7F80_0000);
        run_op(32'hFF80_0000, 1'b0, 1'b0, lat, bc, dc);
        checks++; if (bus.acc_o !== 32'h7FC0_0000) begin errors++; $display("FAIL inf_minus_inf: acc_o=%h required %h", bus.acc_o, 32'h7FC0_0000); end
        checks++; if (bus.invalid_o !== 1'b1) begin errors++; $display("FAIL invalid_flag: invalid_o=%b required 1", bus.invalid_o); end
        run_op(32'h3F80_0000, 1'b0, 1'b1, lat, bc, dc);
        checks++; if (bus.underflow_o !== 1'b1) begin errors++; $display("FAIL in_underflow: underflow_o=%b required 1", bus.underflow_o); end
        checks++; if (bus.acc_o !== 32'h7FC0_0000 || bus.invalid_o !== 1'b1) begin errors++; $display("FAIL nan_propagate: acc_o=%h invalid_o=%b required %h 1", bus.acc_o, bus.invalid_o, 32'h7FC0_0000); end
    endtask

    task automatic test_underflow_result();
        int lat, bc, dc;
        set_acc(32'h0080_0001);
        run_op(32'h8080_0000, 1'b0, 1'b0, lat, bc, dc);
        checks++; if (bus.acc_o !== 32'h0 || bus.underflow_o !== 1'b1) begin errors++; $display("FAIL result_underflow: acc_o=%h underflow_o=%b required 0 1", bus.acc_o, bus.underflow_o); end
        do_clear();
        run_op(32'h3F80_0000, 1'b1, 1'b0, lat, bc, dc);
        checks++; if (bus.overflow_o !== 1'b1 || bus.acc_o !== 32'h3F80_0000) begin errors++; $display("FAIL in_overflow: overflow_o=%b acc_o=%h required 1 %h", bus.overflow_o, bus.acc_o, 32'h3F80_0000); end
    endtask

    task automatic test_back_to_back();
        int accepts;
        do_clear();
        accepts = 0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 32'h3F80_0000;
        // Held valid across 12 edges: accepts land every 6 cycles, the rest are ignored.
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            if (bus.in_ready) accepts++;
        end
        #1;
        bus.in_valid = 1'b0;
        repeat (8) @(negedge clk);
        $display("b2b accepts=%0d acc=%h", accepts, bus.acc_o);
        checks++; if (accepts !== 2) begin errors++; $display("FAIL b2b_accepts: accepts=%0d required 2", accepts); end
        checks++; if (bus.acc_o !== 32'h4000_0000) begin errors++; $display("FAIL b2b_acc: acc_o=%h required %h", bus.acc_o, 32'h4000_0000); end
    endtask

    task automatic test_clear_abort();
        int done_seen;
        set_acc(32'h3F80_0000);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 32'h3F80_0000;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        @(negedge clk);
        checks++; if (bus.acc_o !== 32'h0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL clear_abort_state: acc_o=%h in_ready=%b busy=%b required 0 1 0", bus.acc_o, bus.in_ready, bus.busy); end
        done_seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.done) done_seen++;
            @(negedge clk);
        end
        $display("clear abort acc=%h done_seen=%0d", bus.acc_o, done_seen);
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL clear_no_done: done pulses %0d required 0", done_seen); end
    endtask

    task automatic test_reset_mid_round();
        set_acc(32'h3F80_0000);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 32'h4000_0000; bus.in_overflow = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0; bus.in_overflow = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (bus.done !== 1'b1 || bus.acc_o !== 32'h4040_0000) begin errors++; $display("FAIL round_state: done=%b acc_o=%h required 1 %h", bus.done, bus.acc_o, 32'h4040_0000); end
        rst_n = 1'b0;
        #1;
        $display("reset mid-round acc=%h done=%b busy=%b", bus.acc_o, bus.done, bus.busy);
        checks++; if (bus.acc_o !== 32'h0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL reset_mid_round: acc_o=%h done=%b busy=%b required 0 0 0", bus.acc_o, bus.done, bus.busy); end
        checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL reset_mid_round_flag: overflow_o=%b required 0", bus.overflow_o); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.clear = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 32'h0;
        bus.in_overflow = 1'b0;
        bus.in_underflow = 1'b0;
        test_reset();
        test_basic_add();
        test_cancel_ftz();
        test_rounding();
        test_overflow();
        test_invalid_sticky();
        test_underflow_result();
        test_back_to_back();
        test_clear_abort();
        test_reset_mid_round();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/f32_accum.md
Name: f32_accum

Overview:
- Multi-cycle IEEE-754 single-precision accumulator directly downstream of f32_mult.
- Consumes each product (p on done) and adds it into a running sum register, forming the accumulate half of a sequential dot-product/MAC path.
- Uses the same start/done-style handshake and sticky-flag reporting as the multiplier.
- Round-to-nearest-even; subnormals flushed to zero.

Parameters:
- ACC_RESET, 32'h0000_0000, value loaded into the accumulator on reset and on clear.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous: zero the accumulator (ACC_RESET) and sticky flags; aborts any operation in flight
- in_valid  in  1  operand present (wired to f32_mult done)
- in_data  in  32  f32 addend (wired to f32_mult p)
- in_overflow  in  1  upstream overflow flag, sampled with in_data
- in_underflow  in  1  upstream underflow flag, sampled with in_data
- in_ready  out  1  high only in IDLE with clear low
- acc_o  out  32  current accumulated value
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when acc_o updates
- overflow_o  out  1  sticky: result overflow or in_overflow accepted
- underflow_o  out  1  sticky: result flushed to zero, or in_underflow accepted
- invalid_o  out  1  sticky: NaN produced

Behaviour:
- Reset (async, rst_n=0):
  - acc_o=ACC_RESET; done=0; busy=0; all sticky flags=0; in_ready=1 once rst_n=1; FSM=IDLE.
- Accept: rising edge with in_valid & in_ready latches in_data and ORs in_overflow/in_underflow into the sticky flags.
- FSM IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> IDLE, one cycle per state.
  - In ROUND: acc_o updates and done=1 for exactly that cycle.
  - Fixed latency: done asserts 5 cycles after the accept edge. Next accept is possible on the cycle after done.
- UNPACK:
  - Split both operands into sign, exp, 24-bit significand with hidden bit.
  - exp==0 means zero (FTZ, sign kept).
  - Classify NaN and Inf.
- ALIGN:
  - Swap so the larger magnitude is first.
  - Right-shift the smaller significand by the exponent difference into a 27-bit field (guard, round, sticky).
  - Shifts >=26 leave only sticky.
- ADD: add or subtract significands per the XOR of signs into a 28-bit field. Result sign = sign of the larger magnitude.
- NORM:
  - On carry out: shift right 1, exp+1, sticky ORs in the shifted bit.
  - Otherwise: left shift by the leading-zero count (combinational LZC), exp minus count.
- ROUND:
  - RNE: increment if G & (R | S | lsb).
  - Mantissa overflow after rounding: exp+1.
- Special cases, resolved in UNPACK and passed through:
  - Any NaN input -> acc=7FC00000, invalid_o=1.
  - +Inf + -Inf -> 7FC00000, invalid_o=1.
  - Inf + finite -> that Inf.
  - Exact cancellation -> +0 (00000000); -0 + -0 -> 80000000.
  - Biased exp >= 255 after round -> signed Inf, overflow_o=1.
  - Biased exp <= 0 -> signed zero, underflow_o=1.
- clear:
  - Has priority over everything; takes effect on the next edge.
  - From any state: FSM->IDLE, acc_o=ACC_RESET, flags=0, no done pulse.
  - clear & in_valid in the same cycle: input not accepted (in_ready low).
- in_valid while busy: ignored, not queued. The upstream multiplier's own latency guarantees spacing.
- Sticky flags hold until clear or reset.

Test Plan:
- Reset, clear; accept 3F800000 -> done 5 cycles later, acc_o=3F800000; accept 40000000 -> acc_o=40400000; busy high for 5 cycles each.
- acc=3F800000, accept BF800000 -> acc_o=00000000, no flags; then accept 00000001 (subnormal) -> acc_o=00000000, underflow_o=0.
- Rounding ties: acc=3F800000 + 33800000 -> 3F800000; acc=3F800001 + 33800000 -> 3F800002.
- acc=7F7FFFFF + 7F7FFFFF -> 7F800000, overflow_o=1, still 1 after a further add of 3F800000; clear -> acc_o=0, overflow_o=0.
- acc=7F800000 + FF800000 -> 7FC00000, invalid_o=1; accepting in_data=3F800000 with in_underflow=1 sets underflow_o=1.
- Accept 3F800000, assert clear on 2nd busy cycle -> no done pulse, acc_o=00000000, in_ready=1 the following cycle; rst_n low mid-ROUND -> outputs return to reset values immediately.
